// File: rtl/iob_wb_mem_slave_pkg.sv
// Shared definitions for the Wishbone memory slave: FSM states and
// Wishbone cycle-type / burst-type codes.
package iob_wb_mem_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BEAT,
        DONE
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Contents are never reset.
module iob_ram_sp_be #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic [DATA_W/8-1:0]   we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     d_i,
    output logic [DATA_W-1:0]     d_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < DATA_W/8; i++) begin
            if (we_i[i]) mem[addr_i][i*8 +: 8] <= d_i[i*8 +: 8];
        end
        rdata_q <= mem[addr_i];
    end

    assign d_o = rdata_q;

endmodule

// File: rtl/iob_wb_mem_slave.sv
// Wishbone slave in front of a byte-enabled RAM: programmable wait states,
// linear incrementing bursts, out-of-range error response, beat counters.
module iob_wb_mem_slave
    import iob_wb_mem_slave_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_W       = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       wr_cnt_o
);

    localparam int WADR_W = ADDR_W - 2;

    logic              rst_sync_q;
    logic              rst_n;
    state_e            state_q;
    logic [WADR_W-1:0] wadr_q, wadr_d;
    logic              we_q, ack_q, err_q;
    logic [3:0]        cnt_q;
    logic [15:0]       rd_cnt_q, wr_cnt_q;
    logic              start, beat_take, burst_next, oor_d, mem_we;
    logic [3:0]        mem_be;
    logic [MEM_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_adr_lsb;

    assign unused_adr_lsb = ^wb_adr_i[1:0];

    // Single stage: release is seen at the first edge, so the FSM samples on the second.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) rst_sync_q <= 1'b0;
        else           rst_sync_q <= 1'b1;
    end
    assign rst_n = rst_sync_q;

    always_comb begin
        start      = (state_q == IDLE) && wb_cyc_i && wb_stb_i;
        beat_take  = (state_q == BEAT) && wb_cyc_i && wb_stb_i;
        burst_next = beat_take && (wb_cti_i == CTI_INCR) && (wb_bte_i == BTE_LINEAR);
        wadr_d     = wadr_q;
        if (start)           wadr_d = wb_adr_i[ADDR_W-1:2];
        else if (burst_next) wadr_d = wadr_q + WADR_W'(1);
        oor_d    = (wadr_d >> MEM_W) != '0;
        mem_we   = beat_take && we_q && ack_q;
        mem_be   = mem_we ? wb_sel_i : '0;
        // Reads look one address ahead so the registered RAM output lines up with BEAT.
        mem_addr = mem_we ? wadr_q[MEM_W-1:0] : wadr_d[MEM_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wadr_q   <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            wadr_q <= wadr_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        we_q <= wb_we_i;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= BEAT;
                            ack_q   <= !oor_d;
                            err_q   <= oor_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (!wb_cyc_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= BEAT;
                        ack_q   <= !oor_d;
                        err_q   <= oor_d;
                    end
                end
                BEAT: begin
                    if (beat_take && ack_q) begin
                        if (we_q) wr_cnt_q <= wr_cnt_q + 16'd1;
                        else      rd_cnt_q <= rd_cnt_q + 16'd1;
                    end
                    if (burst_next) begin
                        ack_q <= !oor_d;
                        err_q <= oor_d;
                    end else begin
                        state_q <= wb_cyc_i ? DONE : IDLE;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    iob_ram_sp_be #(
        .ADDR_W(MEM_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (mem_be),
        .addr_i (mem_addr),
        .d_i    (wb_dat_i),
        .d_o    (mem_rdata)
    );

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = (ack_q && !we_q) ? mem_rdata : '0;
    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_iob_wb_mem_slave.sv
// Randomised Wishbone traffic against an associative-array memory model,
// plus directed wait-state, byte-lane, range, burst, abort and reset cases.
module tb_iob_wb_mem_slave;

    localparam int ADDR_W      = 32;
    localparam int MEM_W       = 12;
    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
    logic [31:0] wb_dat = '0;
    logic [2:0]  wb_cti = '0;
    logic [1:0]  wb_bte = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack, wb_err;
    logic [15:0] rd_cnt, wr_cnt;

    iob_wb_mem_slave #(
        .ADDR_W(ADDR_W),
        .MEM_W(MEM_W),
        .DATA_W(32),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_dat_i(wb_dat),
        .wb_cti_i(wb_cti), .wb_bte_i(wb_bte),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack), .wb_err_o(wb_err),
        .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] mem_m [int unsigned];
    logic [3:0]  vld_m [int unsigned];
    logic [15:0] rd_m = '0;
    logic [15:0] wr_m = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Called at #1 after a rising edge with the slave idle; returns likewise.
    task automatic xfer(input logic [31:0] adr, input logic we, input int nb,
                        input logic [1:0] bte, input logic [3:0] sel0, input logic [31:0] dat0);
        int          lat;
        int          neff;
        int unsigned w;
        logic        oor;
        logic [31:0] m;
        lat  = 0;
        neff = (bte == 2'b00) ? nb : 1;
        wb_adr = adr; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1; wb_bte = bte;
        wb_sel = sel0; wb_dat = dat0;
        wb_cti = (nb > 1) ? 3'b010 : 3'b000;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(wb_ack || wb_err) && lat < 32);
        check_eq("first_latency", lat, WAIT_CYCLES + 1);
        for (int b = 0; b < neff; b++) begin
            w   = (adr >> 2) + b;
            oor = w >= (32'd1 << MEM_W);
            check_eq("ack", {31'b0, wb_ack}, {31'b0, !oor});
            check_eq("err", {31'b0, wb_err}, {31'b0, oor});
            if (!we && !oor && vld_m.exists(w)) begin
                m = lane_mask(vld_m[w]);
                check_eq("rdata", wb_dat_o & m, mem_m[w] & m);
            end
            if (b > 0) begin
                wb_sel = 4'($urandom);
                wb_dat = $urandom;
            end
            if (nb == 1) wb_cti = ($urandom_range(0, 2) == 0) ? 3'b001 :
                                  ($urandom_range(0, 1) == 0) ? 3'b111 : 3'b000;
            else         wb_cti = (b == nb - 1) ? 3'b111 : 3'b010;
            if (!oor) begin
                if (we) begin
                    if (!vld_m.exists(w)) begin
                        vld_m[w] = '0;
                        mem_m[w] = '0;
                    end
                    m        = lane_mask(wb_sel);
                    mem_m[w] = (mem_m[w] & ~m) | (wb_dat & m);
                    vld_m[w] = vld_m[w] | wb_sel;
                    wr_m++;
                end else begin
                    rd_m++;
                end
            end
            @(posedge clk); #1;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        check_eq("done_resp", {30'b0, wb_ack, wb_err}, 32'd0);
        check_eq("done_dat", wb_dat_o, 32'd0);
        check_eq("rd_cnt", {16'b0, rd_cnt}, {16'b0, rd_m});
        check_eq("wr_cnt", {16'b0, wr_cnt}, {16'b0, wr_m});
        @(posedge clk); #1;
    endtask

    task automatic abort_write(input logic [31:0] adr);
        wb_adr = adr; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        wb_sel = 4'hF; wb_dat = 32'h0BAD_F00D; wb_cti = 3'b000; wb_bte = 2'b00;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        for (int i = 0; i < WAIT_CYCLES + 2; i++) begin
            @(posedge clk); #1;
            check_eq("abort_resp", {30'b0, wb_ack, wb_err}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          nb;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_resp", {30'b0, wb_ack, wb_err}, 32'd0);
        check_eq("rst_dat", wb_dat_o, 32'd0);
        check_eq("rst_cnt", {rd_cnt, wr_cnt}, 32'd0);
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write/read with wait states
        xfer(32'h10, 1'b1, 1, 2'b00, 4'hF, 32'hDEAD_BEEF);
        xfer(32'h10, 1'b0, 1, 2'b00, 4'hF, 32'h0);
        check_eq("deadbeef", mem_m[32'h4], 32'hDEAD_BEEF);

        // Byte-lane merge
        xfer(32'h20, 1'b1, 1, 2'b00, 4'hF, 32'hFFFF_FFFF);
        xfer(32'h22, 1'b1, 1, 2'b00, 4'b0001, 32'h0000_00AA);
        xfer(32'h20, 1'b0, 1, 2'b00, 4'hF, 32'h0);

        // Out of range read
        xfer(32'h0000_4000, 1'b0, 1, 2'b00, 4'hF, 32'h0);

        // Abort during WAIT leaves memory untouched
        xfer(32'h30, 1'b1, 1, 2'b00, 4'hF, 32'h1357_9BDF);
        abort_write(32'h30);
        xfer(32'h30, 1'b0, 1, 2'b00, 4'hF, 32'h0);

        // Burst crossing the top of memory: ack, ack, err, err
        xfer(32'h3FF8, 1'b1, 1, 2'b00, 4'hF, 32'hA5A5_0FFE);
        xfer(32'h3FFC, 1'b1, 1, 2'b00, 4'hF, 32'hA5A5_0FFF);
        xfer(32'h3FF8, 1'b0, 4, 2'b00, 4'hF, 32'h0);

        // Unsupported burst type collapses to one beat
        xfer(32'h40, 1'b1, 3, 2'b01, 4'hF, 32'h2468_ACE0);
        xfer(32'h40, 1'b0, 3, 2'b10, 4'hF, 32'h0);

        // Reset during a write BEAT: immediate clear, no write
        wb_adr = 32'h10; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        wb_sel = 4'hF; wb_dat = 32'h1234_5678; wb_cti = 3'b000; wb_bte = 2'b00;
        for (int i = 0; i < 32 && !wb_ack; i++) begin
            @(posedge clk); #1;
        end
        check_eq("pre_rst_ack", {31'b0, wb_ack}, 32'd1);
        #2 arst_n = 1'b0;
        #1;
        check_eq("mid_rst_resp", {30'b0, wb_ack, wb_err}, 32'd0);
        check_eq("mid_rst_dat", wb_dat_o, 32'd0);
        check_eq("mid_rst_cnt", {rd_cnt, wr_cnt}, 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        rd_m = '0; wr_m = '0;
        @(posedge clk);
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #1;
        xfer(32'h10, 1'b0, 1, 2'b00, 4'hF, 32'h0);

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0)
                a = (32'h4000 << $urandom_range(0, 16)) | ($urandom & 32'h3FFF);
            else
                a = $urandom & 32'h3FFF;
            nb = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 5) : 1;
            xfer(a, 1'($urandom), nb, ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 4'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
